// File: rtl/control_unit.sv
// Instruction sequencer: fetches 16-bit words over req/ack, decodes and issues one datapath cycle each.
// Optional CTRL_SINGLE_STEP_EN adds a step input gating each fetch.
module control_unit #(
    parameter int unsigned PC_WIDTH = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                clk,
    input  logic                rst,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic                step,
`endif
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic                imem_req,
    input  logic                imem_ack,
    input  logic [15:0]         imem_data,
    input  logic                alu_zero,
    input  logic                alu_carry,
    output logic                alu_en,
    output logic [3:0]          alu_opcode,
    output logic [7:0]          user_write_data,
    output logic [3:0]          write_addr,
    output logic [3:0]          ra_addr,
    output logic [3:0]          rb_addr,
    output logic                write_en,
    output logic                flag_z,
    output logic                flag_c,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted
);
    localparam int unsigned OP_W  = 4;
    localparam int unsigned IMM_W = 8;

    localparam logic [OP_W-1:0] OP_LDI  = 4'hC;
    localparam logic [OP_W-1:0] OP_JMP  = 4'hD;
    localparam logic [OP_W-1:0] OP_BZ   = 4'hE;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

    state_t              r_state;
    logic [OP_W-1:0]     r_op;
    logic [IMM_W-1:0]    r_imm;
    logic [PC_WIDTH-1:0] r_pc;
    logic                r_imem_req;
    logic                r_alu_en;
    logic [OP_W-1:0]     r_alu_opcode;
    logic [IMM_W-1:0]    r_user_write_data;
    logic [3:0]          r_write_addr;
    logic [3:0]          r_ra_addr;
    logic [3:0]          r_rb_addr;
    logic                r_write_en;
    logic                r_flag_z;
    logic                r_flag_c;
    logic                r_halted;

    logic                w_ack;
    logic                w_step_ok;
    logic [OP_W-1:0]     w_op;
    logic                w_is_alu;
    logic                w_is_ldi;

    assign w_ack    = (r_state == S_FETCH) && r_imem_req && imem_ack;
    assign w_op     = imem_data[15:12];
    assign w_is_alu = (w_op < OP_LDI);
    assign w_is_ldi = (w_op == OP_LDI);

`ifdef CTRL_SINGLE_STEP_EN
    logic r_step_pend;

    // Sticky step request, consumed by the fetch it releases
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_step_pend <= 1'b0;
        end else if (w_ack) begin
            r_step_pend <= 1'b0;
        end else if (step) begin
            r_step_pend <= 1'b1;
        end
    end

    assign w_step_ok = r_step_pend | step;
`else
    assign w_step_ok = 1'b1;
`endif

    // Sequencer; decoded strobes are loaded on the fetch edge so they are valid for exactly the EXEC cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state           <= S_FETCH;
            r_op              <= '0;
            r_imm             <= '0;
            r_pc              <= PC_WIDTH'(RESET_PC);
            r_imem_req        <= 1'b0;
            r_alu_en          <= 1'b0;
            r_alu_opcode      <= '0;
            r_user_write_data <= '0;
            r_write_addr      <= '0;
            r_ra_addr         <= '0;
            r_rb_addr         <= '0;
            r_write_en        <= 1'b0;
            r_flag_z          <= 1'b0;
            r_flag_c          <= 1'b0;
            r_halted          <= 1'b0;
        end else begin
            r_alu_en          <= 1'b0;
            r_alu_opcode      <= '0;
            r_user_write_data <= '0;
            r_write_addr      <= '0;
            r_ra_addr         <= '0;
            r_rb_addr         <= '0;
            r_write_en        <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (w_ack) begin
                        r_op              <= w_op;
                        r_imm             <= imem_data[7:0];
                        r_pc              <= r_pc + PC_WIDTH'(1);
                        r_imem_req        <= 1'b0;
                        r_state           <= S_EXEC;
                        r_write_en        <= w_is_alu | w_is_ldi;
                        r_alu_en          <= w_is_alu;
                        r_alu_opcode      <= w_is_alu ? w_op : 4'h0;
                        r_write_addr      <= (w_is_alu | w_is_ldi) ? imem_data[11:8] : 4'h0;
                        r_ra_addr         <= w_is_alu ? imem_data[7:4] : 4'h0;
                        r_rb_addr         <= w_is_alu ? imem_data[3:0] : 4'h0;
                        r_user_write_data <= w_is_ldi ? imem_data[7:0] : 8'h00;
                    end else begin
                        r_imem_req <= w_step_ok;
                    end
                end
                S_EXEC: begin
                    if (r_op < OP_LDI) begin
                        r_flag_z <= alu_zero;
                        r_flag_c <= alu_carry;
                    end
                    if ((r_op == OP_JMP) || ((r_op == OP_BZ) && r_flag_z)) begin
                        r_pc <= PC_WIDTH'(r_imm);
                    end
                    if (r_op == OP_HALT) begin
                        r_state    <= S_HALT;
                        r_halted   <= 1'b1;
                        r_imem_req <= 1'b0;
                    end else begin
                        r_state    <= S_FETCH;
                        r_imem_req <= w_step_ok;
                    end
                end
                S_HALT: begin
                    r_imem_req <= 1'b0;
                    r_halted   <= 1'b1;
                end
                default: begin
                    r_state    <= S_FETCH;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr       = r_pc;
    assign pc              = r_pc;
    assign imem_req        = r_imem_req;
    assign alu_en          = r_alu_en;
    assign alu_opcode      = r_alu_opcode;
    assign user_write_data = r_user_write_data;
    assign write_addr      = r_write_addr;
    assign ra_addr         = r_ra_addr;
    assign rb_addr         = r_rb_addr;
    assign write_en        = r_write_en;
    assign flag_z          = r_flag_z;
    assign flag_c          = r_flag_c;
    assign halted          = r_halted;

endmodule
